// File: rtl/fts_pkg.sv
// Package: fts_pkg
// Shared types and helpers for the frame transmit scheduler.
//   fts_state_t : launch sequencer states (IDLE -> LAUNCH -> WAIT -> IDLE)
//   MISS_W      : width of the saturating missed-tick counter
//   cnt_width() : width of the transmit-window counter for a given TX_CYCLES
package fts_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } fts_state_t;

    localparam int MISS_W = 8;

    // The window counter only needs to reach TX_CYCLES-2, so $clog2(TX_CYCLES)
    // is always wide enough. The floor of 1 keeps TX_CYCLES=2 legal.
    function automatic int cnt_width(input int tx_cycles);
        return (tx_cycles > 2) ? $clog2(tx_cycles) : 1;
    endfunction

endpackage

// File: rtl/fts_ch_hold.sv
// Module: fts_ch_hold
// One channel's holding register for the frame transmit scheduler.
// Ports:
//   clk    in   1  clock
//   srst   in   1  synchronous active-high reset
//   valid  in   1  producer has a sample on data
//   launch in   1  a frame is being launched on this edge
//   data   in   W  producer sample
//   hold   out  W  last accepted sample
//   fresh  out  1  hold contains a sample not yet sent
//   ready  out  1  channel can accept a sample (hold not fresh)
module fts_ch_hold #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         valid,
    input  logic         launch,
    input  logic [W-1:0] data,
    output logic [W-1:0] hold,
    output logic         fresh,
    output logic         ready
);

    logic [W-1:0] hold_reg;
    logic         fresh_reg;
    logic         load;

    // ready is purely a function of registered state, so producers never see
    // a combinational path from the tick strobe.
    assign load = valid & ~fresh_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            hold_reg  <= '0;
            fresh_reg <= 1'b0;
        end else begin
            if (load) begin
                hold_reg <= data;
            end
            // A sample accepted on the launch edge missed this frame's
            // snapshot, so it must stay fresh for the next one.
            if (load) begin
                fresh_reg <= 1'b1;
            end else if (launch) begin
                fresh_reg <= 1'b0;
            end
        end
    end

    assign hold  = hold_reg;
    assign fresh = fresh_reg;
    assign ready = ~fresh_reg;

endmodule

// File: rtl/frame_tx_scheduler.sv
// Module: frame_tx_scheduler
// Collects one sample per channel and launches a packed NCH*W-bit frame to the
// transmitter on an enabled frame-slot tick, then keeps the transmitter free of
// re-triggers for TX_CYCLES cycles while counting any ticks that arrive then.
// Ports:
//   clk_i      in   1      clock
//   rst_i      in   1      synchronous reset, active-high
//   en_i       in   1      launch enable (gates new launches only)
//   tick_i     in   1      frame-slot strobe from the transmitter
//   data_i     in   NCH*W  channel samples, ch c at [c*W +: W]
//   valid_i    in   NCH    per-channel sample valid
//   ready_o    out  NCH    per-channel ready (holding register not fresh)
//   start_o    out  1      one-cycle launch pulse
//   frame_o    out  NCH*W  packed frame, ch0 in LSBs
//   fresh_o    out  NCH    channels carrying new data in frame_o
//   busy_o     out  1      launch issued, transmit window running
//   overrun_o  out  1      sticky: tick seen while not idle
//   miss_cnt_o out  8      saturating count of missed ticks
//   clr_i      in   1      clears overrun_o and miss_cnt_o
module frame_tx_scheduler
    import fts_pkg::*;
#(
    parameter int NCH        = 3,
    parameter int W          = 9,
    parameter int TX_CYCLES  = 45,
    parameter int SEND_STALE = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              tick_i,
    input  logic [NCH*W-1:0]  data_i,
    input  logic [NCH-1:0]    valid_i,
    output logic [NCH-1:0]    ready_o,
    output logic              start_o,
    output logic [NCH*W-1:0]  frame_o,
    output logic [NCH-1:0]    fresh_o,
    output logic              busy_o,
    output logic              overrun_o,
    output logic [MISS_W-1:0] miss_cnt_o,
    input  logic              clr_i
);

    localparam int               CNT_W     = cnt_width(TX_CYCLES);
    // LAUNCH takes one cycle of the window, WAIT covers the remaining
    // TX_CYCLES-1, counting 0 .. TX_CYCLES-2.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TX_CYCLES - 2);
    localparam logic             STALE_OK  = (SEND_STALE != 0);
    localparam logic [MISS_W-1:0] MISS_MAX = {MISS_W{1'b1}};

    fts_state_t        state_reg;
    fts_state_t        state_next;
    logic [CNT_W-1:0]  cnt_reg;

    logic [NCH*W-1:0]  hold_bus;
    logic [NCH-1:0]    fresh_vec;
    logic [NCH-1:0]    ready_vec;

    logic [NCH*W-1:0]  frame_reg;
    logic [NCH-1:0]    fresh_out_reg;
    logic              overrun_reg;
    logic [MISS_W-1:0] miss_cnt_reg;

    logic              launch;
    logic              miss;
    logic              start;
    logic              busy;

    // ------------------------------------------------------------------
    // Per-channel holding registers
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            fts_ch_hold #(
                .W(W)
            ) u_hold (
                .clk    (clk_i),
                .srst   (rst_i),
                .valid  (valid_i[gi]),
                .launch (launch),
                .data   (data_i[gi*W +: W]),
                .hold   (hold_bus[gi*W +: W]),
                .fresh  (fresh_vec[gi]),
                .ready  (ready_vec[gi])
            );
        end
    endgenerate

    // A tick is only taken in IDLE; any tick outside IDLE is a miss, whatever
    // en_i or the fresh bits say.
    assign launch = (state_reg == IDLE) & tick_i & en_i & ((|fresh_vec) | STALE_OK);
    assign miss   = tick_i & (state_reg != IDLE);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE:    if (launch) state_next = LAUNCH;
            LAUNCH:  state_next = WAIT;
            WAIT:    if (cnt_reg == WAIT_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        unique case (state_reg)
            IDLE:    ;
            LAUNCH: begin
                start = 1'b1;
                busy  = 1'b1;
            end
            WAIT:    busy = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Window counter: zero everywhere except WAIT, where it runs up
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_reg != WAIT)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame / fresh snapshot, held until the next launch
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_reg     <= '0;
            fresh_out_reg <= '0;
        end else if (launch) begin
            frame_reg     <= hold_bus;
            fresh_out_reg <= fresh_vec;
        end
    end

    // ------------------------------------------------------------------
    // Overrun flag and saturating miss counter; clear beats a miss
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            overrun_reg  <= 1'b0;
            miss_cnt_reg <= '0;
        end else if (miss) begin
            overrun_reg <= 1'b1;
            if (miss_cnt_reg != MISS_MAX) begin
                miss_cnt_reg <= miss_cnt_reg + 1'b1;
            end
        end
    end

    assign ready_o    = ready_vec;
    assign start_o    = start;
    assign busy_o     = busy;
    assign frame_o    = frame_reg;
    assign fresh_o    = fresh_out_reg;
    assign overrun_o  = overrun_reg;
    assign miss_cnt_o = miss_cnt_reg;

endmodule

// File: tb/tb_frame_tx_scheduler.sv
module tb_frame_tx_scheduler;

    localparam int NCH   = 3;
    localparam int W     = 9;
    localparam int TX    = 45;
    localparam int STALE = 0;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             tick;
    logic             clr;
    logic [NCH*W-1:0] data;
    logic [NCH-1:0]   valid;
    logic [NCH-1:0]   ready_o;
    logic             start_o;
    logic [NCH*W-1:0] frame_o;
    logic [NCH-1:0]   fresh_o;
    logic             busy_o;
    logic             overrun_o;
    logic [7:0]       miss_cnt_o;

    always #5 clk = ~clk;

    frame_tx_scheduler #(
        .NCH(NCH), .W(W), .TX_CYCLES(TX), .SEND_STALE(STALE)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .en_i       (en),
        .tick_i     (tick),
        .data_i     (data),
        .valid_i    (valid),
        .ready_o    (ready_o),
        .start_o    (start_o),
        .frame_o    (frame_o),
        .fresh_o    (fresh_o),
        .busy_o     (busy_o),
        .overrun_o  (overrun_o),
        .miss_cnt_o (miss_cnt_o),
        .clr_i      (clr)
    );

    int vectors    = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Reference model: transmit window kept as an absolute cycle interval.
    // ------------------------------------------------------------------
    int             cyc = 0;
    logic [W-1:0]   m_hold [NCH];
    bit             m_fresh[NCH];
    logic [NCH*W-1:0] m_frame;
    logic [NCH-1:0] m_fresh_o;
    int             m_win_start;
    int             m_win_end;
    bit             m_over;
    int             m_miss;
    int             launch_cyc[$];

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_hold[c]  = '0;
            m_fresh[c] = 1'b0;
        end
        m_frame     = '0;
        m_fresh_o   = '0;
        m_win_start = -10;
        m_win_end   = -10;
        m_over      = 1'b0;
        m_miss      = 0;
    endtask

    // Applies the inputs of cycle cyc; afterwards cyc names the next cycle.
    task automatic model_step();
        bit any;
        bit in_win;
        bit go;
        if (rst) begin
            model_reset();
        end else begin
            any = 1'b0;
            for (int c = 0; c < NCH; c++) any |= m_fresh[c];
            in_win = (cyc >= m_win_start) && (cyc <= m_win_end);
            go     = tick && en && (any || (STALE != 0)) && !in_win;
            if (clr) begin
                m_over = 1'b0;
                m_miss = 0;
            end else if (tick && in_win) begin
                m_over = 1'b1;
                if (m_miss < 255) m_miss++;
            end
            if (go) begin
                for (int c = 0; c < NCH; c++) begin
                    m_frame[c*W +: W] = m_hold[c];
                    m_fresh_o[c]      = m_fresh[c];
                end
                m_win_start = cyc + 1;
                m_win_end   = cyc + TX;
            end
            for (int c = 0; c < NCH; c++) begin
                if (valid[c] && !m_fresh[c]) begin
                    m_hold[c]  = data[c*W +: W];
                    m_fresh[c] = 1'b1;
                end else if (go) begin
                    m_fresh[c] = 1'b0;
                end
            end
        end
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            if (miscompares <= 40)
                $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        logic [NCH-1:0] exp_ready;
        @(posedge clk);
        #1;
        model_step();
        for (int c = 0; c < NCH; c++) exp_ready[c] = !m_fresh[c];
        chk("start_o",   64'(start_o),   64'(cyc == m_win_start));
        chk("busy_o",    64'(busy_o),    64'((cyc >= m_win_start) && (cyc <= m_win_end)));
        chk("ready_o",   64'(ready_o),   64'(exp_ready));
        chk("frame_o",   64'(frame_o),   64'(m_frame));
        chk("fresh_o",   64'(fresh_o),   64'(m_fresh_o));
        chk("overrun_o", 64'(overrun_o), 64'(m_over));
        chk("miss_cnt",  64'(miss_cnt_o), 64'(m_miss));
        if (start_o === 1'b1) begin
            launch_cyc.push_back(cyc);
            $display("launch cyc=%0d frame=%07h fresh=%b miss=%0d", cyc, frame_o, fresh_o, miss_cnt_o);
        end
    endtask

    task automatic quiet();
        tick  = 1'b0;
        valid = '0;
        clr   = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        quiet();
        while (busy_o !== 1'b0 && n < 100) begin
            step();
            n++;
        end
        chk("idle_wait", 64'(busy_o), 64'd0);
    endtask

    typedef struct {
        logic [NCH-1:0]   load;
        logic [W-1:0]     d0, d1, d2;
        logic             exp_start;
        logic [NCH*W-1:0] exp_frame;
        logic [NCH-1:0]   exp_fresh;
    } vec_t;

    vec_t vecs[5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        // Unloaded channels carry junk that must be ignored.
        vecs[0] = '{3'b111, 9'd1,   9'd2,   9'd3,   1'b1, 27'h00C0401, 3'b111};
        vecs[1] = '{3'b010, 9'h0F0, 9'd5,   9'h111, 1'b1, 27'h00C0A01, 3'b010};
        vecs[2] = '{3'b000, 9'h1AB, 9'h0CD, 9'h0EF, 1'b0, 27'h00C0A01, 3'b010};
        vecs[3] = '{3'b101, 9'h1FF, 9'h033, 9'h100, 1'b1, 27'h4000BFF, 3'b101};
        vecs[4] = '{3'b110, 9'h077, 9'h0AA, 9'h055, 1'b1, 27'h15555FF, 3'b110};

        model_reset();
        rst = 1'b1; en = 1'b1; tick = 1'b0; clr = 1'b0; valid = '0; data = '0;
        step();
        step();
        chk("rst_ready", 64'(ready_o), 64'd7);
        chk("rst_busy",  64'(busy_o),  64'd0);
        chk("rst_frame", 64'(frame_o), 64'd0);
        rst = 1'b0;

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 5; v++) begin
            wait_idle();
            valid = vecs[v].load;
            data  = {vecs[v].d2, vecs[v].d1, vecs[v].d0};
            step();
            valid = '0;
            tick  = 1'b1;
            en    = 1'b1;
            step();
            tick  = 1'b0;
            chk($sformatf("vec%0d_start", v), 64'(start_o), 64'(vecs[v].exp_start));
            chk($sformatf("vec%0d_frame", v), 64'(frame_o), 64'(vecs[v].exp_frame));
            chk($sformatf("vec%0d_fresh", v), 64'(fresh_o), 64'(vecs[v].exp_fresh));
        end

        // ---------------- load on the launch edge ----------------
        wait_idle();
        valid = 3'b001; data = 27'd7;
        step();
        tick = 1'b1; valid = 3'b100; data = {9'd9, 9'h1C3, 9'h0A5};
        step();
        quiet();
        chk("same_start", 64'(start_o), 64'd1);
        chk("same_fresh", 64'(fresh_o), 64'b001);
        chk("same_ready", 64'(ready_o), 64'b011);
        wait_idle();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("next_fresh", 64'(fresh_o), 64'b100);
        chk("next_ch2",   64'(frame_o[26:18]), 64'd9);

        // ---------------- en_i low blocks launches ----------------
        wait_idle();
        en = 1'b0;
        valid = 3'b010; data = 27'($urandom);
        step();
        valid = '0;
        for (int t = 0; t < 3; t++) begin
            tick = 1'b1; step();
            chk("en_low_start", 64'(start_o), 64'd0);
            tick = 1'b0; step(); step();
        end
        en = 1'b1; tick = 1'b1;
        step();
        tick = 1'b0;
        chk("en_high_start", 64'(start_o), 64'd1);
        // en falling mid-window: window completes, nothing relaunches
        step(); step();
        en = 1'b0;
        wait_idle();
        valid = 3'b001; step(); valid = '0;
        tick = 1'b1; step(); tick = 1'b0;
        chk("en_fall_start", 64'(start_o), 64'd0);
        en = 1'b1;

        // ---------------- ticks every 20 cycles ----------------
        wait_idle();
        clr = 1'b1; step(); clr = 1'b0;
        launch_cyc.delete();
        valid = 3'b111; data = 27'($urandom);
        step();
        for (int t = 0; t < 7; t++) begin
            tick = 1'b1; data = 27'($urandom);
            step();
            tick = 1'b0;
            for (int i = 0; i < 19; i++) begin
                data = 27'($urandom);
                step();
            end
        end
        valid = '0;
        chk("tick20_launches", 64'(launch_cyc.size()), 64'd3);
        chk("tick20_gap0", 64'(launch_cyc[1] - launch_cyc[0]), 64'd60);
        chk("tick20_gap1", 64'(launch_cyc[2] - launch_cyc[1]), 64'd60);
        chk("tick20_over", 64'(overrun_o), 64'd1);
        chk("tick20_miss", 64'(miss_cnt_o), 64'd4);
        clr = 1'b1; step(); clr = 1'b0;
        chk("clr_over", 64'(overrun_o), 64'd0);
        chk("clr_miss", 64'(miss_cnt_o), 64'd0);

        // ---------------- miss counter saturation ----------------
        wait_idle();
        valid = 3'b111; tick = 1'b1;
        for (int i = 0; i < 400; i++) begin
            data = 27'($urandom);
            step();
        end
        chk("sat_miss", 64'(miss_cnt_o), 64'd255);
        for (int i = 0; i < 10 && busy_o !== 1'b1; i++) step();
        clr = 1'b1;
        step();
        chk("clr_wins_miss", 64'(miss_cnt_o), 64'd0);
        chk("clr_wins_over", 64'(overrun_o), 64'd0);
        quiet();

        // ---------------- reset inside the window ----------------
        wait_idle();
        valid = 3'b001; data = 27'h55; step(); valid = '0;
        tick = 1'b1; step(); tick = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst = 1'b1; step(); rst = 1'b0;
        chk("wrst_busy",  64'(busy_o),  64'd0);
        chk("wrst_ready", 64'(ready_o), 64'd7);
        chk("wrst_frame", 64'(frame_o), 64'd0);
        chk("wrst_fresh", 64'(fresh_o), 64'd0);
        valid = 3'b010; data = {9'd0, 9'd77, 9'd0}; step(); valid = '0;
        tick = 1'b1; step(); tick = 1'b0;
        chk("post_rst_start", 64'(start_o), 64'd1);
        chk("post_rst_frame", 64'(frame_o), 64'({9'd0, 9'd77, 9'd0}));

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            en    = ($urandom_range(0, 9) != 0);
            tick  = ($urandom_range(0, 7) == 0);
            valid = 3'($urandom_range(0, 7));
            data  = 27'($urandom);
            clr   = ($urandom_range(0, 49) == 0);
            rst   = ($urandom_range(0, 499) == 0);
            step();
        end
        quiet();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
